alu_iter: RTL

Parametrised, handshaked successor to the combinational integer ALU. It executes the eight base RV integer ops in one registered cycle and the eight RV M-extension ops (multiply/divide/remainder) iteratively, one bit per cycle. It sits between the decode/operand-fetch stage and writeback, so the core can stall on long-latency arithmetic through valid/ready.

---
 rtl/alu_iter_if.sv | 26 ++
 rtl/alu_iter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_iter_if.sv
// Request/response bundle of the iterative ALU: operand handshake in, result handshake out.
interface alu_iter_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      op;
    logic            aux;
    logic            mext;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            out_err;

    modport master (
        output in_valid, a, b, op, aux, mext, out_ready,
        input  in_ready, out_valid, result, out_err
    );

    modport slave (
        input  in_valid, a, b, op, aux, mext, out_ready,
        output in_ready, out_valid, result, out_err
    );
endinterface

// File: rtl/alu_iter.sv
// Handshaked ALU: base RV ops in one registered cycle, M-extension ops iterated one bit per cycle.
// Define ALU_DIV_EN to build DIV/DIVU/REM/REMU; otherwise they complete at once with out_err=1.
module alu_iter #(
    parameter int XLEN = 32
) (
    input logic       clk,
    input logic       rst,
    alu_iter_if.slave bus
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(XLEN);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
`ifdef ALU_DIV_EN
        DIV,
`endif
        DONE
    } state_t;

    state_t            state_reg;
    logic [SHW:0]      cnt_reg;
    // Multiply: {partial product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   opnd_reg;
    logic              neg_reg;
    logic              sel_reg;
    logic [XLEN-1:0]   result_reg;
    logic              err_reg;

    logic              accept;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   base_res;
    logic              a_sgn;
    logic              b_sgn;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] product;

    assign bus.in_ready  = !rst && (state_reg == IDLE || (state_reg == DONE && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.out_err   = err_reg;
    assign shamt         = bus.b[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (bus.op)
            3'd0: base_res = bus.aux ? (bus.a - bus.b) : (bus.a + bus.b);
            3'd1: base_res = bus.a << shamt;
            3'd2: base_res[0] = $signed(bus.a) < $signed(bus.b);
            3'd3: base_res[0] = bus.a < bus.b;
            3'd4: base_res = bus.a ^ bus.b;
            3'd5: begin
                if (bus.aux) base_res = $signed(bus.a) >>> shamt;
                else         base_res = bus.a >> shamt;
            end
            3'd6: base_res = bus.a | bus.b;
            default: base_res = bus.a & bus.b;
        endcase
    end

    // Which operands are treated as signed depends on the M-ext op; iteration runs on magnitudes.
    always_comb begin
        if (bus.op[2]) begin
            a_sgn = !bus.op[0] && bus.a[XLEN-1];
            b_sgn = !bus.op[0] && bus.b[XLEN-1];
        end else begin
            a_sgn = (bus.op[1:0] == 2'd1 || bus.op[1:0] == 2'd2) && bus.a[XLEN-1];
            b_sgn = (bus.op[1:0] == 2'd1) && bus.b[XLEN-1];
        end
        a_mag = a_sgn ? -bus.a : bus.a;
        b_mag = b_sgn ? -bus.b : bus.b;
    end

    assign mul_sum = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    assign product = neg_reg ? -acc_reg : acc_reg;

`ifdef ALU_DIV_EN
    logic              neg_rem_reg;
    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     div_diff;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    assign rem_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    assign div_diff  = rem_shift - {1'b0, opnd_reg};
    assign quo_fix   = neg_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    assign rem_fix   = neg_rem_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            neg_reg    <= 1'b0;
            sel_reg    <= 1'b0;
            result_reg <= '0;
            err_reg    <= 1'b0;
`ifdef ALU_DIV_EN
            neg_rem_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                // cnt counts XLEN shift steps; the cnt==0 cycle applies the sign fixup.
                MUL: begin
                    if (cnt_reg != '0) begin
                        acc_reg <= {mul_sum, acc_reg[XLEN-1:1]};
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        result_reg <= sel_reg ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
                        err_reg    <= 1'b0;
                        state_reg  <= DONE;
                    end
                end
`ifdef ALU_DIV_EN
                DIV: begin
                    if (cnt_reg != '0) begin
                        if (div_diff[XLEN]) acc_reg <= {rem_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
                        else                acc_reg <= {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        result_reg <= sel_reg ? rem_fix : quo_fix;
                        err_reg    <= 1'b0;
                        state_reg  <= DONE;
                    end
                end
`endif
                DONE: if (bus.out_ready) state_reg <= IDLE;
                default: ;
            endcase

            // Accept only happens in IDLE/DONE, so this overrides the DONE->IDLE retire above.
            if (accept) begin
                cnt_reg <= CNT_INIT;
                err_reg <= 1'b0;
                if (!bus.mext) begin
                    result_reg <= base_res;
                    state_reg  <= DONE;
                end else if (!bus.op[2]) begin
                    acc_reg   <= {{XLEN{1'b0}}, b_mag};
                    opnd_reg  <= a_mag;
                    neg_reg   <= a_sgn ^ b_sgn;
                    sel_reg   <= (bus.op[1:0] != 2'd0);
                    state_reg <= MUL;
                end else begin
`ifdef ALU_DIV_EN
                    // Divide by zero keeps an all-ones quotient, so its sign is never flipped.
                    acc_reg     <= {{XLEN{1'b0}}, a_mag};
                    opnd_reg    <= b_mag;
                    neg_reg     <= (a_sgn ^ b_sgn) && (bus.b != '0);
                    neg_rem_reg <= a_sgn;
                    sel_reg     <= bus.op[1];
                    state_reg   <= DIV;
`else
                    result_reg <= '0;
                    err_reg    <= 1'b1;
                    state_reg  <= DONE;
`endif
                end
            end
        end
    end
endmodule
